// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer.
package reorder_buffer_pkg;

    localparam int unsigned ROB_SIZE  = 16;
    localparam int unsigned ROB_IDX_W = 4;

    typedef logic [4:0]  rob_id_t;
    typedef logic [4:0]  reg_t;
    typedef logic [31:0] data_t;
    typedef logic [31:0] addr_t;

    localparam rob_id_t ROB_ID_RESET = '0;
    localparam reg_t    REG_RESET    = '0;
    localparam data_t   DATA_RESET   = '0;

    typedef enum logic [1:0] {
        ROB_NORMAL = 2'd0,
        ROB_BRANCH = 2'd1,
        ROB_STORE  = 2'd2
    } rob_type_e;

    // Tag N lives in slot N-1; tag 16 maps to slot 15 through 4-bit wrap.
    function automatic logic [ROB_IDX_W-1:0] tag_to_idx(input rob_id_t tag);
        return tag[ROB_IDX_W-1:0] - 4'd1;
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// 16-entry in-order-retire reorder buffer with operand bypass and
// mispredict rollback on branch commit.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        alloc_valid_from_dispatcher,
    input  logic [4:0]  alloc_rd_from_dispatcher,
    input  logic [31:0] alloc_pc_from_dispatcher,
    input  logic [1:0]  alloc_type_from_dispatcher,
    input  logic        alloc_pred_taken_from_dispatcher,
    output logic [4:0]  rob_id_to_dispatcher,
    output logic        full_to_dispatcher,
    input  logic [4:0]  query1_id_from_dispatcher,
    input  logic [4:0]  query2_id_from_dispatcher,
    output logic        ready1_to_dispatcher,
    output logic [31:0] value1_to_dispatcher,
    output logic        ready2_to_dispatcher,
    output logic [31:0] value2_to_dispatcher,
    input  logic        alu_valid_from_cdb,
    input  logic [4:0]  alu_rob_id_from_cdb,
    input  logic [31:0] alu_value_from_cdb,
    input  logic        alu_taken_from_cdb,
    input  logic [31:0] alu_target_from_cdb,
    input  logic        lsb_valid_from_cdb,
    input  logic [4:0]  lsb_rob_id_from_cdb,
    input  logic [31:0] lsb_value_from_cdb,
    output logic        commit_flag_to_cdb,
    output logic [4:0]  rd_to_reg,
    output logic [31:0] V_to_reg,
    output logic [4:0]  Q_to_reg,
    output logic [31:0] commit_pc_to_dbg,
    output logic        store_commit_to_lsb,
    output logic [4:0]  store_id_to_lsb,
    output logic        rollback_flag_to_cdb,
    output logic [31:0] target_pc_to_fetcher
);

    logic [ROB_IDX_W-1:0] r_head;
    logic [ROB_IDX_W-1:0] r_tail;
    logic [4:0]           r_count;
    logic [ROB_SIZE-1:0]  r_busy;
    logic [ROB_SIZE-1:0]  r_ready;
    logic [ROB_SIZE-1:0]  r_taken;
    logic [ROB_SIZE-1:0]  r_pred;
    reg_t                 r_rd     [ROB_SIZE];
    addr_t                r_pc     [ROB_SIZE];
    addr_t                r_target [ROB_SIZE];
    data_t                r_value  [ROB_SIZE];
    rob_type_e            r_type   [ROB_SIZE];

    logic                 w_full;
    logic                 w_alloc;
    logic                 w_commit;
    logic                 w_mispredict;
    logic                 w_alu_hit;
    logic                 w_lsb_hit;
    logic [ROB_IDX_W-1:0] w_alu_idx;
    logic [ROB_IDX_W-1:0] w_lsb_idx;
    rob_id_t              w_head_tag;

    assign w_full       = (r_count == 5'(ROB_SIZE));
    assign w_alloc      = alloc_valid_from_dispatcher && !w_full;
    assign w_commit     = r_busy[r_head] && r_ready[r_head];
    assign w_mispredict = w_commit && (r_type[r_head] == ROB_BRANCH)
                          && (r_taken[r_head] != r_pred[r_head]);
    assign w_alu_idx    = tag_to_idx(alu_rob_id_from_cdb);
    assign w_lsb_idx    = tag_to_idx(lsb_rob_id_from_cdb);
    assign w_alu_hit    = alu_valid_from_cdb && (alu_rob_id_from_cdb != ROB_ID_RESET)
                          && r_busy[w_alu_idx];
    assign w_lsb_hit    = lsb_valid_from_cdb && (lsb_rob_id_from_cdb != ROB_ID_RESET)
                          && r_busy[w_lsb_idx];
    assign w_head_tag   = {1'b0, r_head} + 5'd1;

    assign full_to_dispatcher   = w_full;
    assign rob_id_to_dispatcher = {1'b0, r_tail} + 5'd1;

    // Pointer, occupancy and per-entry status; rollback wipes everything and
    // swallows any allocation or writeback arriving on the same edge.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_busy  <= '0;
            r_ready <= '0;
        end else if (rdy_in) begin
            if (w_mispredict) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_busy  <= '0;
                r_ready <= '0;
            end else begin
                if (w_alu_hit) r_ready[w_alu_idx] <= 1'b1;
                if (w_lsb_hit) r_ready[w_lsb_idx] <= 1'b1;
                if (w_commit) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + 4'd1;
                end
                if (w_alloc) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_tail          <= r_tail + 4'd1;
                end
                r_count <= r_count + {4'b0, w_alloc} - {4'b0, w_commit};
            end
        end
    end

    // Entry payload; contents of non-busy slots are never observed.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !w_mispredict) begin
            if (w_alloc) begin
                r_rd[r_tail]   <= alloc_rd_from_dispatcher;
                r_pc[r_tail]   <= alloc_pc_from_dispatcher;
                r_type[r_tail] <= rob_type_e'(alloc_type_from_dispatcher);
                r_pred[r_tail] <= alloc_pred_taken_from_dispatcher;
            end
            if (w_alu_hit) begin
                r_value[w_alu_idx]  <= alu_value_from_cdb;
                r_taken[w_alu_idx]  <= alu_taken_from_cdb;
                r_target[w_alu_idx] <= alu_target_from_cdb;
            end
            if (w_lsb_hit) begin
                r_value[w_lsb_idx] <= lsb_value_from_cdb;
            end
        end
    end

    // Registered commit, store-release and redirect outputs for the head entry.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            commit_flag_to_cdb   <= 1'b0;
            rd_to_reg            <= REG_RESET;
            V_to_reg             <= DATA_RESET;
            Q_to_reg             <= ROB_ID_RESET;
            commit_pc_to_dbg     <= '0;
            store_commit_to_lsb  <= 1'b0;
            store_id_to_lsb      <= ROB_ID_RESET;
            rollback_flag_to_cdb <= 1'b0;
            target_pc_to_fetcher <= '0;
        end else if (rdy_in) begin
            commit_flag_to_cdb   <= w_commit;
            store_commit_to_lsb  <= w_commit && (r_type[r_head] == ROB_STORE);
            rollback_flag_to_cdb <= w_mispredict;
            rd_to_reg            <= (w_commit && (r_type[r_head] == ROB_NORMAL))
                                    ? r_rd[r_head] : REG_RESET;
            if (w_commit) begin
                V_to_reg         <= r_value[r_head];
                Q_to_reg         <= w_head_tag;
                commit_pc_to_dbg <= r_pc[r_head];
                if (r_type[r_head] == ROB_STORE) store_id_to_lsb <= w_head_tag;
            end
            if (w_mispredict) begin
                target_pc_to_fetcher <= r_taken[r_head] ? r_target[r_head]
                                                        : r_pc[r_head] + 32'd4;
            end
        end
    end

    // Operand 1 bypass: same-cycle CDB result first, then completed entry.
    always_comb begin
        ready1_to_dispatcher = 1'b0;
        value1_to_dispatcher = DATA_RESET;
        if (query1_id_from_dispatcher != ROB_ID_RESET) begin
            if (alu_valid_from_cdb && alu_rob_id_from_cdb == query1_id_from_dispatcher) begin
                ready1_to_dispatcher = 1'b1;
                value1_to_dispatcher = alu_value_from_cdb;
            end else if (lsb_valid_from_cdb && lsb_rob_id_from_cdb == query1_id_from_dispatcher) begin
                ready1_to_dispatcher = 1'b1;
                value1_to_dispatcher = lsb_value_from_cdb;
            end else begin
                ready1_to_dispatcher = r_busy[tag_to_idx(query1_id_from_dispatcher)]
                                       && r_ready[tag_to_idx(query1_id_from_dispatcher)];
                value1_to_dispatcher = r_value[tag_to_idx(query1_id_from_dispatcher)];
            end
        end
    end

    // Operand 2 bypass: same-cycle CDB result first, then completed entry.
    always_comb begin
        ready2_to_dispatcher = 1'b0;
        value2_to_dispatcher = DATA_RESET;
        if (query2_id_from_dispatcher != ROB_ID_RESET) begin
            if (alu_valid_from_cdb && alu_rob_id_from_cdb == query2_id_from_dispatcher) begin
                ready2_to_dispatcher = 1'b1;
                value2_to_dispatcher = alu_value_from_cdb;
            end else if (lsb_valid_from_cdb && lsb_rob_id_from_cdb == query2_id_from_dispatcher) begin
                ready2_to_dispatcher = 1'b1;
                value2_to_dispatcher = lsb_value_from_cdb;
            end else begin
                ready2_to_dispatcher = r_busy[tag_to_idx(query2_id_from_dispatcher)]
                                       && r_ready[tag_to_idx(query2_id_from_dispatcher)];
                value2_to_dispatcher = r_value[tag_to_idx(query2_id_from_dispatcher)];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic        clk, rst, rdy;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic [31:0] alloc_pc;
    logic [1:0]  alloc_type;
    logic        alloc_pred;
    logic [4:0]  rob_id;
    logic        full;
    logic [4:0]  q1_id, q2_id;
    logic        ready1, ready2;
    logic [31:0] value1, value2;
    logic        alu_valid, alu_taken, lsb_valid;
    logic [4:0]  alu_id, lsb_id;
    logic [31:0] alu_value, alu_target, lsb_value;
    logic        commit_flag, store_commit, rollback_flag;
    logic [4:0]  rd_out, q_out, store_id;
    logic [31:0] v_out, commit_pc, target_pc;

    int n_chk  = 0;
    int n_pass = 0;

    reorder_buffer dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
        .alloc_valid_from_dispatcher(alloc_valid),
        .alloc_rd_from_dispatcher(alloc_rd),
        .alloc_pc_from_dispatcher(alloc_pc),
        .alloc_type_from_dispatcher(alloc_type),
        .alloc_pred_taken_from_dispatcher(alloc_pred),
        .rob_id_to_dispatcher(rob_id),
        .full_to_dispatcher(full),
        .query1_id_from_dispatcher(q1_id),
        .query2_id_from_dispatcher(q2_id),
        .ready1_to_dispatcher(ready1),
        .value1_to_dispatcher(value1),
        .ready2_to_dispatcher(ready2),
        .value2_to_dispatcher(value2),
        .alu_valid_from_cdb(alu_valid),
        .alu_rob_id_from_cdb(alu_id),
        .alu_value_from_cdb(alu_value),
        .alu_taken_from_cdb(alu_taken),
        .alu_target_from_cdb(alu_target),
        .lsb_valid_from_cdb(lsb_valid),
        .lsb_rob_id_from_cdb(lsb_id),
        .lsb_value_from_cdb(lsb_value),
        .commit_flag_to_cdb(commit_flag),
        .rd_to_reg(rd_out),
        .V_to_reg(v_out),
        .Q_to_reg(q_out),
        .commit_pc_to_dbg(commit_pc),
        .store_commit_to_lsb(store_commit),
        .store_id_to_lsb(store_id),
        .rollback_flag_to_cdb(rollback_flag),
        .target_pc_to_fetcher(target_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          tag;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [1:0]  ty;
        logic        pred;
        logic        done;
        logic [31:0] val;
        logic        taken;
        logic [31:0] tgt;
    } ent_t;

    ent_t        mq[$];
    ent_t        ne;
    int          next_tag = 1;
    int          presize;
    bit          m_com, m_mis;
    logic        e_commit, e_store, e_rb;
    logic [4:0]  e_rd, e_q, e_sid;
    logic [31:0] e_v, e_pc, e_tpc;

    // Program order is the queue order; retirement takes the front once done.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            next_tag = 1;
            e_commit = 0; e_store = 0; e_rb = 0;
            e_rd = 0; e_q = 0; e_sid = 0; e_v = 0; e_pc = 0; e_tpc = 0;
        end else if (rdy) begin
            presize  = mq.size();
            m_com    = 0;
            m_mis    = 0;
            e_commit = 0; e_store = 0; e_rb = 0; e_rd = 0;
            if (presize > 0 && mq[0].done) begin
                m_com    = 1;
                e_commit = 1;
                e_v      = mq[0].val;
                e_q      = 5'(mq[0].tag);
                e_pc     = mq[0].pc;
                if (mq[0].ty == ROB_NORMAL) e_rd = mq[0].rd;
                if (mq[0].ty == ROB_STORE) begin
                    e_store = 1;
                    e_sid   = 5'(mq[0].tag);
                end
                if (mq[0].ty == ROB_BRANCH && mq[0].taken != mq[0].pred) begin
                    m_mis = 1;
                    e_rb  = 1;
                    e_tpc = mq[0].taken ? mq[0].tgt : mq[0].pc + 32'd4;
                end
            end
            if (m_mis) begin
                mq.delete();
                next_tag = 1;
            end else begin
                foreach (mq[i]) begin
                    if (alu_valid && int'(alu_id) == mq[i].tag) begin
                        mq[i].done = 1; mq[i].val = alu_value;
                        mq[i].taken = alu_taken; mq[i].tgt = alu_target;
                    end
                    if (lsb_valid && int'(lsb_id) == mq[i].tag) begin
                        mq[i].done = 1; mq[i].val = lsb_value;
                    end
                end
                if (m_com) void'(mq.pop_front());
                if (alloc_valid && presize < 16) begin
                    ne.tag = next_tag; ne.rd = alloc_rd; ne.pc = alloc_pc;
                    ne.ty = alloc_type; ne.pred = alloc_pred; ne.done = 0;
                    ne.val = 0; ne.taken = 0; ne.tgt = 0;
                    mq.push_back(ne);
                    next_tag = (next_tag % 16) + 1;
                end
            end
        end
    end

    function automatic logic [32:0] qmodel(input logic [4:0] id);
        if (id == 0) return 33'd0;
        if (alu_valid && alu_id == id) return {1'b1, alu_value};
        if (lsb_valid && lsb_id == id) return {1'b1, lsb_value};
        foreach (mq[i]) if (mq[i].tag == int'(id) && mq[i].done) return {1'b1, mq[i].val};
        return 33'd0;
    endfunction

    logic [32:0] qe1, qe2;

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("commit_flag", {31'b0, commit_flag}, {31'b0, e_commit});
            chk("rd_to_reg", {27'b0, rd_out}, {27'b0, e_rd});
            chk("store_commit", {31'b0, store_commit}, {31'b0, e_store});
            chk("rollback", {31'b0, rollback_flag}, {31'b0, e_rb});
            if (e_commit) begin
                chk("V_to_reg", v_out, e_v);
                chk("Q_to_reg", {27'b0, q_out}, {27'b0, e_q});
                chk("commit_pc", commit_pc, e_pc);
            end
            if (e_store) chk("store_id", {27'b0, store_id}, {27'b0, e_sid});
            if (e_rb) chk("target_pc", target_pc, e_tpc);
            chk("full", {31'b0, full}, (mq.size() == 16) ? 32'd1 : 32'd0);
            chk("rob_id", {27'b0, rob_id}, 32'(next_tag));
            qe1 = qmodel(q1_id);
            qe2 = qmodel(q2_id);
            chk("ready1", {31'b0, ready1}, {31'b0, qe1[32]});
            chk("ready2", {31'b0, ready2}, {31'b0, qe2[32]});
            if (qe1[32]) chk("value1", value1, qe1[31:0]);
            if (qe2[32]) chk("value2", value2, qe2[31:0]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_in();
        alloc_valid = 0; alloc_rd = 0; alloc_pc = 0; alloc_type = 0; alloc_pred = 0;
        alu_valid = 0; alu_id = 0; alu_value = 0; alu_taken = 0; alu_target = 0;
        lsb_valid = 0; lsb_id = 0; lsb_value = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        clear_in();
    endtask

    task automatic alloc(input logic [4:0] rd, input logic [31:0] pc,
                         input logic [1:0] ty, input logic pred);
        alloc_valid = 1; alloc_rd = rd; alloc_pc = pc; alloc_type = ty; alloc_pred = pred;
    endtask

    task automatic alu_wb(input logic [4:0] id, input logic [31:0] v,
                          input logic tk, input logic [31:0] tg);
        alu_valid = 1; alu_id = id; alu_value = v; alu_taken = tk; alu_target = tg;
    endtask

    task automatic lsb_wb(input logic [4:0] id, input logic [31:0] v);
        lsb_valid = 1; lsb_id = id; lsb_value = v;
    endtask

    // Asynchronous reset: outputs must drop without waiting for a clock edge.
    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst commit_flag", {31'b0, commit_flag}, 32'd0);
        chk("rst rd_to_reg", {27'b0, rd_out}, 32'd0);
        chk("rst V_to_reg", v_out, 32'd0);
        chk("rst Q_to_reg", {27'b0, q_out}, 32'd0);
        chk("rst rob_id", {27'b0, rob_id}, 32'd1);
        chk("rst full", {31'b0, full}, 32'd0);
        @(posedge clk);
        #2;
        rst = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1; rdy = 1; q1_id = 0; q2_id = 0;
        clear_in();
        #2;
        do_reset();

        // Basic alloc / writeback / commit with same-cycle bypass.
        alloc(5'd5, 32'h10, ROB_NORMAL, 1'b0);
        tick();
        chk("t1 rob_id", {27'b0, rob_id}, 32'd2);
        alu_wb(5'd1, 32'h2A, 1'b0, 32'h0);
        q1_id = 5'd1;
        #1;
        chk("t1 bypass ready1", {31'b0, ready1}, 32'd1);
        chk("t1 bypass value1", value1, 32'h2A);
        tick();
        chk("t1 no commit yet", {31'b0, commit_flag}, 32'd0);
        tick();
        chk("t1 commit_flag", {31'b0, commit_flag}, 32'd1);
        chk("t1 rd_to_reg", {27'b0, rd_out}, 32'd5);
        chk("t1 V_to_reg", v_out, 32'h2A);
        chk("t1 Q_to_reg", {27'b0, q_out}, 32'd1);
        tick();
        chk("t1 pulse ends", {31'b0, commit_flag}, 32'd0);
        q1_id = 0;

        // Fill to 16, overflow alloc ignored, commit one, tag wraps to 1.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc(5'(i + 1), 32'h1000 + 32'(i * 4), ROB_NORMAL, 1'b0);
            tick();
        end
        chk("t2 full", {31'b0, full}, 32'd1);
        chk("t2 rob_id wrap", {27'b0, rob_id}, 32'd1);
        alloc(5'd31, 32'hDEAD, ROB_NORMAL, 1'b0);
        tick();
        chk("t2 17th ignored", {31'b0, full}, 32'd1);
        alu_wb(5'd1, 32'h77, 1'b0, 32'h0);
        q2_id = 5'd16;
        tick();
        tick();
        chk("t2 commit tag1", {27'b0, q_out}, 32'd1);
        chk("t2 not full", {31'b0, full}, 32'd0);
        chk("t2 next tag", {27'b0, rob_id}, 32'd1);
        alloc(5'd20, 32'h2000, ROB_NORMAL, 1'b0);
        tick();
        chk("t2 refull", {31'b0, full}, 32'd1);
        q2_id = 0;

        // Out-of-order writeback, in-order retirement.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            alloc(5'(i), 32'h20 + 32'(i * 4), ROB_NORMAL, 1'b0);
            tick();
        end
        q1_id = 5'd2; q2_id = 5'd3;
        alu_wb(5'd3, 32'h33, 1'b0, 32'h0); tick();
        alu_wb(5'd2, 32'h22, 1'b0, 32'h0); tick();
        lsb_wb(5'd1, 32'h11); tick();
        chk("t3 no early commit", {31'b0, commit_flag}, 32'd0);
        tick();
        chk("t3 commit1 Q", {27'b0, q_out}, 32'd1);
        chk("t3 commit1 V", v_out, 32'h11);
        tick();
        chk("t3 commit2 Q", {27'b0, q_out}, 32'd2);
        tick();
        chk("t3 commit3 Q", {27'b0, q_out}, 32'd3);
        chk("t3 commit3 V", v_out, 32'h33);
        q1_id = 0; q2_id = 0;

        // Taken mispredict with younger entries; same-cycle alloc/writeback dropped.
        do_reset();
        alloc(5'd0, 32'h100, ROB_BRANCH, 1'b0); tick();
        alloc(5'd7, 32'h104, ROB_NORMAL, 1'b0); tick();
        alloc(5'd8, 32'h108, ROB_NORMAL, 1'b0); tick();
        alu_wb(5'd1, 32'h0, 1'b1, 32'h200);
        lsb_wb(5'd2, 32'h99);
        tick();
        alloc(5'd10, 32'h10C, ROB_NORMAL, 1'b0);
        alu_wb(5'd3, 32'h77, 1'b0, 32'h0);
        tick();
        chk("t4 rollback", {31'b0, rollback_flag}, 32'd1);
        chk("t4 target_pc", target_pc, 32'h200);
        chk("t4 branch rd", {27'b0, rd_out}, 32'd0);
        chk("t4 rob_id cleared", {27'b0, rob_id}, 32'd1);
        tick();
        chk("t4 rollback pulse", {31'b0, rollback_flag}, 32'd0);
        tick();
        chk("t4 no younger commit", {31'b0, commit_flag}, 32'd0);

        // Not-taken mispredict redirects to pc+4.
        alloc(5'd0, 32'h300, ROB_BRANCH, 1'b1); tick();
        alloc(5'd4, 32'h304, ROB_NORMAL, 1'b0); tick();
        alu_wb(5'd1, 32'h0, 1'b0, 32'h999); tick();
        tick();
        chk("t4b rollback", {31'b0, rollback_flag}, 32'd1);
        chk("t4b target_pc", target_pc, 32'h304);

        // Correctly predicted branch retires without redirect.
        tick();
        alloc(5'd0, 32'h400, ROB_BRANCH, 1'b1); tick();
        alu_wb(5'd1, 32'h0, 1'b1, 32'h500); tick();
        tick();
        chk("t4c commit", {31'b0, commit_flag}, 32'd1);
        chk("t4c no rollback", {31'b0, rollback_flag}, 32'd0);

        // Store commit.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            alloc(5'(i), 32'h40 + 32'(i * 4), ROB_NORMAL, 1'b0);
            tick();
        end
        alloc(5'd12, 32'h50, ROB_STORE, 1'b0); tick();
        alu_wb(5'd1, 32'h1, 1'b0, 32'h0); lsb_wb(5'd4, 32'h4444); tick();
        alu_wb(5'd2, 32'h2, 1'b0, 32'h0); tick();
        alu_wb(5'd3, 32'h3, 1'b0, 32'h0); tick();
        tick();
        chk("t5 not yet store", {31'b0, store_commit}, 32'd0);
        tick();
        chk("t5 store_commit", {31'b0, store_commit}, 32'd1);
        chk("t5 store_id", {27'b0, store_id}, 32'd4);
        chk("t5 store rd", {27'b0, rd_out}, 32'd0);
        chk("t5 commit_flag", {31'b0, commit_flag}, 32'd1);

        // Stall with ready head, then resume; then mid-stream reset.
        do_reset();
        alloc(5'd9, 32'h60, ROB_NORMAL, 1'b0); tick();
        alu_wb(5'd1, 32'h5, 1'b0, 32'h0); tick();
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            alloc(5'd11, 32'h64, ROB_NORMAL, 1'b0);
            tick();
            chk("t6 stalled no commit", {31'b0, commit_flag}, 32'd0);
            chk("t6 stalled rob_id", {27'b0, rob_id}, 32'd2);
        end
        rdy = 1;
        tick();
        chk("t6 resume commit", {31'b0, commit_flag}, 32'd1);
        chk("t6 resume rd", {27'b0, rd_out}, 32'd9);
        chk("t6 resume V", v_out, 32'h5);
        alloc(5'd13, 32'h68, ROB_NORMAL, 1'b0);
        do_reset();
        alloc(5'd3, 32'h70, ROB_NORMAL, 1'b0); tick();
        alu_wb(5'd1, 32'hAB, 1'b0, 32'h0); tick();
        tick();
        chk("t6 post-reset tag", {27'b0, q_out}, 32'd1);
        chk("t6 post-reset rd", {27'b0, rd_out}, 32'd3);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
